// File: rtl/vga_mmio_pkg.sv
// Shared constants for the VGA MMIO register block: register offsets,
// the CTRL bit layout and the default base address of the register window.
package vga_mmio_pkg;

  localparam logic [15:0] DEFAULT_BASE_ADR = 16'hFF00;

  localparam logic [2:0] OFF_VALUE  = 3'd0;
  localparam logic [2:0] OFF_P1     = 3'd1;
  localparam logic [2:0] OFF_P2     = 3'd2;
  localparam logic [2:0] OFF_P3     = 3'd3;
  localparam logic [2:0] OFF_P4     = 3'd4;
  localparam logic [2:0] OFF_CTRL   = 3'd5;
  localparam logic [2:0] OFF_STATUS = 3'd6;

  localparam int CTRL_SYNC_BIT = 0;
  localparam int NUM_SHADOW    = 5;

endpackage

// File: rtl/vga_mmio_if.sv
// CPU-side load/store bus of the VGA MMIO block; the CPU drives the
// master modport, the register block implements the slave modport.
interface vga_mmio_if;
  logic        memwrite;
  logic        memread;
  logic [15:0] adr;
  logic [15:0] writedata;
  logic [15:0] rdata;
  logic        rvalid;
  logic        hit;

  modport master (
    output memwrite, memread, adr, writedata,
    input  rdata, rvalid, hit
  );

  modport slave (
    input  memwrite, memread, adr, writedata,
    output rdata, rvalid, hit
  );
endinterface

// File: rtl/vga_mmio_vsync_edge.sv
// Registers the active-low vsync once and flags the cycle where it falls,
// which marks the start of vertical blanking.
module vsync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic vblank_start
);

  logic vs_d;
  logic vs_q;

  always_comb begin
    vs_d = vsync;
  end

  // Reset to high so a falling edge needs vsync seen high first.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= vs_d;
    end
  end

  assign vblank_start = vs_q & ~vsync;

endmodule

// File: rtl/vga_mmio.sv
// Memory-mapped display operand registers: CPU stores land in shadow copies
// that are committed to the live outputs either immediately or at vblank.
module vga_mmio
  import vga_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADR = DEFAULT_BASE_ADR,
  parameter int          FRAME_W  = 15
) (
  input  logic          clk,
  input  logic          rst,
  vga_mmio_if.slave     bus,
  input  logic          vsync,
  output logic [15:0]   value,
  output logic [15:0]   p1,
  output logic [15:0]   p2,
  output logic [15:0]   p3,
  output logic [15:0]   p4
);

  logic [15:0]        shadow_q [NUM_SHADOW];
  logic [15:0]        shadow_d [NUM_SHADOW];
  logic [15:0]        live_q   [NUM_SHADOW];
  logic [15:0]        live_d   [NUM_SHADOW];
  logic               sync_q, sync_d;
  logic               pending_q, pending_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  logic               hit_s;
  logic [2:0]         off_s;
  logic               store_hit_s;
  logic               shadow_store_s;
  logic               load_hit_s;
  logic               commit_s;
  logic               vblank_start_s;
  logic [14:0]        frame_ext_s;
  logic [15:0]        reg_rd_s;

  vsync_edge u_vsync_edge (
    .clk          (clk),
    .rst          (rst),
    .vsync        (vsync),
    .vblank_start (vblank_start_s)
  );

  assign hit_s       = (bus.adr[15:3] == BASE_ADR[15:3]);
  assign off_s       = bus.adr[2:0];
  assign frame_ext_s = 15'(frame_q);

  always_comb begin
    store_hit_s    = bus.memwrite & hit_s;
    shadow_store_s = store_hit_s & (off_s <= OFF_P4);
    load_hit_s     = bus.memread & hit_s & ~bus.memwrite;
    // With SYNC set, pending updates wait for the start of vblank.
    commit_s       = pending_q & (~sync_q | vblank_start_s);
  end

  always_comb begin
    for (int i = 0; i < NUM_SHADOW; i++) begin
      if (store_hit_s && (off_s == 3'(i))) begin
        shadow_d[i] = bus.writedata;
      end else begin
        shadow_d[i] = shadow_q[i];
      end
      // Commit takes the pre-store shadow; a same-edge store stays pending.
      if (commit_s) begin
        live_d[i] = shadow_q[i];
      end else begin
        live_d[i] = live_q[i];
      end
    end

    if (store_hit_s && (off_s == OFF_CTRL)) begin
      sync_d = bus.writedata[CTRL_SYNC_BIT];
    end else begin
      sync_d = sync_q;
    end

    if (shadow_store_s) begin
      pending_d = 1'b1;
    end else if (commit_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (vblank_start_s) begin
      frame_d = frame_q + {{(FRAME_W-1){1'b0}}, 1'b1};
    end else begin
      frame_d = frame_q;
    end
  end

  always_comb begin
    case (off_s)
      OFF_VALUE:  reg_rd_s = shadow_q[0];
      OFF_P1:     reg_rd_s = shadow_q[1];
      OFF_P2:     reg_rd_s = shadow_q[2];
      OFF_P3:     reg_rd_s = shadow_q[3];
      OFF_P4:     reg_rd_s = shadow_q[4];
      OFF_CTRL:   reg_rd_s = {15'h0000, sync_q};
      OFF_STATUS: reg_rd_s = {frame_ext_s, pending_q};
      default:    reg_rd_s = 16'h0000;
    endcase

    if (load_hit_s) begin
      rdata_d  = reg_rd_s;
      rvalid_d = 1'b1;
    end else begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SHADOW; i++) begin
        shadow_q[i] <= 16'h0000;
        live_q[i]   <= 16'h0000;
      end
      sync_q    <= 1'b1;
      pending_q <= 1'b0;
      frame_q   <= '0;
      rdata_q   <= 16'h0000;
      rvalid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SHADOW; i++) begin
        shadow_q[i] <= shadow_d[i];
        live_q[i]   <= live_d[i];
      end
      sync_q    <= sync_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign value      = live_q[0];
  assign p1         = live_q[1];
  assign p2         = live_q[2];
  assign p3         = live_q[3];
  assign p4         = live_q[4];
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.hit    = hit_s;

endmodule

// File: tb/tb_vga_mmio.sv
// Scoreboard bench for vga_mmio: a register-level reference model predicts
// load responses (queued) and live outputs; a monitor compares every cycle.
module tb_vga_mmio;
  import vga_mmio_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic [15:0] value, p1, p2, p3, p4;

  vga_mmio_if bus_if ();

  vga_mmio #(.BASE_ADR(BASE), .FRAME_W(15)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus_if),
    .vsync (vsync),
    .value (value),
    .p1    (p1),
    .p2    (p2),
    .p3    (p3),
    .p4    (p4)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: register file as seen by software.
  logic [15:0] m_shadow [5];
  logic [15:0] m_live   [5];
  bit          m_pending;
  bit          m_sync;
  bit          m_vsprev;
  logic [14:0] m_frame;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] off);
    if (off < 3'd5)       return m_shadow[off];
    else if (off == 3'd5) return {15'h0000, m_sync};
    else if (off == 3'd6) return {m_frame, m_pending};
    else                  return 16'h0000;
  endfunction

  // One clock cycle of stimulus; the model advances with the DUT edge.
  task automatic step(input bit r, input bit we, input bit re,
                      input logic [15:0] a, input logic [15:0] wd, input bit vs);
    bit         h, vbs, commit;
    logic [2:0] off;
    @(negedge clk);
    rst = r;
    bus_if.memwrite  = we;
    bus_if.memread   = re;
    bus_if.adr       = a;
    bus_if.writedata = wd;
    vsync            = vs;
    h   = (a[15:3] == BASE[15:3]);
    off = a[2:0];
    #1;
    check("hit", {79'b0, bus_if.hit}, {79'b0, h});
    vbs    = m_vsprev && !vs;
    commit = m_pending && (!m_sync || vbs);
    if (!r && re && h && !we) exp_q.push_back('{cyc + 1, m_read(off)});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 5; i++) begin
        m_shadow[i] = 16'h0000;
        m_live[i]   = 16'h0000;
      end
      m_pending = 1'b0;
      m_sync    = 1'b1;
      m_vsprev  = 1'b1;
      m_frame   = 15'h0000;
      exp_q.delete();
    end else begin
      if (commit) for (int i = 0; i < 5; i++) m_live[i] = m_shadow[i];
      if (we && h && off < 3'd5) m_shadow[off] = wd;
      if (we && h && off == 3'd5) m_sync = wd[0];
      if (we && h && off < 3'd5) m_pending = 1'b1;
      else if (commit)           m_pending = 1'b0;
      if (vbs) m_frame = m_frame + 15'd1;
      m_vsprev = vs;
    end
  endtask

  task automatic idle(input bit vs);
    step(1'b0, 1'b0, 1'b0, BASE, 16'h0000, vs);
  endtask

  // Monitor: pops a queued load response whenever one is due, checks live outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   due_now;
      exp_t e;
      due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("rvalid", {79'b0, bus_if.rvalid}, {79'b0, due_now});
      if (due_now) begin
        e = exp_q.pop_front();
        if (bus_if.rvalid) check("rdata", {64'b0, bus_if.rdata}, {64'b0, e.data});
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
      check("live", {value, p1, p2, p3, p4},
            {m_live[0], m_live[1], m_live[2], m_live[3], m_live[4]});
    end
  end

  initial begin
    rst = 1'b1;
    vsync = 1'b1;
    bus_if.memwrite = 1'b0;
    bus_if.memread = 1'b0;
    bus_if.adr = BASE;
    bus_if.writedata = 16'h0000;

    step(1'b1, 1'b0, 1'b0, BASE, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 1'b0, BASE, 16'h0000, 1'b1);
    mon_en = 1'b1;
    #2;
    check("reset_live", {value, p1, p2, p3, p4}, 80'h0);
    check("reset_rvalid", {79'b0, bus_if.rvalid}, 80'h0);

    // Reset readback of CTRL and STATUS.
    step(1'b0, 1'b0, 1'b1, BASE + 16'd5, 16'h0000, 1'b1);
    #2 check("reset_ctrl", {64'b0, bus_if.rdata}, {64'b0, 16'h0001});
    step(1'b0, 1'b0, 1'b1, BASE + 16'd6, 16'h0000, 1'b1);
    #2 check("reset_status", {64'b0, bus_if.rdata}, {64'b0, 16'h0000});

    // SYNC=1: store waits for vblank.
    step(1'b0, 1'b1, 1'b0, BASE, 16'h1234, 1'b1);
    idle(1'b1);
    idle(1'b1);
    #2 check("sync_hold_value", {64'b0, value}, {64'b0, 16'h0000});
    step(1'b0, 1'b0, 1'b1, BASE + 16'd6, 16'h0000, 1'b0);
    #2 check("vblank_value", {64'b0, value}, {64'b0, 16'h1234});
    check("pending_before", {64'b0, bus_if.rdata}, {64'b0, 16'h0001});
    step(1'b0, 1'b0, 1'b1, BASE + 16'd6, 16'h0000, 1'b1);
    #2 check("status_after", {64'b0, bus_if.rdata}, {64'b0, 16'h0002});

    // SYNC=0: two-cycle lag.
    step(1'b0, 1'b1, 1'b0, BASE + 16'd5, 16'h0000, 1'b1);
    step(1'b0, 1'b1, 1'b0, BASE + 16'd3, 16'hABCD, 1'b1);
    #2 check("p3_lag1", {64'b0, p3}, {64'b0, 16'h0000});
    idle(1'b1);
    #2 check("p3_lag2", {64'b0, p3}, {64'b0, 16'hABCD});

    // Store colliding with a vblank commit.
    step(1'b0, 1'b1, 1'b0, BASE + 16'd5, 16'h0001, 1'b1);
    step(1'b0, 1'b1, 1'b0, BASE + 16'd1, 16'h0005, 1'b1);
    step(1'b0, 1'b1, 1'b0, BASE + 16'd1, 16'h0009, 1'b0);
    #2 check("collide_p1", {64'b0, p1}, {64'b0, 16'h0005});
    step(1'b0, 1'b0, 1'b1, BASE + 16'd6, 16'h0000, 1'b1);
    #2 check("collide_pending", {79'b0, bus_if.rdata[0]}, {79'b0, 1'b1});
    idle(1'b0);
    #2 check("collide_p1_next", {64'b0, p1}, {64'b0, 16'h0009});

    // Miss store, then reset while pending.
    step(1'b0, 1'b1, 1'b0, 16'h0005, 16'h7777, 1'b1);
    step(1'b0, 1'b1, 1'b0, BASE + 16'd2, 16'h5555, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b1);
    step(1'b1, 1'b1, 1'b1, BASE + 16'd5, 16'h0000, 1'b0);
    #2 check("rst_live", {value, p1, p2, p3, p4}, 80'h0);
    step(1'b0, 1'b0, 1'b1, BASE + 16'd5, 16'h0000, 1'b1);
    #2 check("rst_sync", {64'b0, bus_if.rdata}, {64'b0, 16'h0001});

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] a, wd;
      bit we, re, vs, r;
      a  = ($urandom_range(0, 9) < 8) ? (BASE | 16'($urandom_range(0, 7))) : 16'($urandom);
      wd = 16'($urandom);
      we = ($urandom_range(0, 9) < 3);
      re = ($urandom_range(0, 9) < 4);
      vs = ($urandom_range(0, 3) != 0) ? vsync : ~vsync;
      r  = ($urandom_range(0, 199) == 0);
      step(r, we, re, a, wd, vs);
    end

    // Frame counter wrap.
    step(1'b1, 1'b0, 1'b0, BASE, 16'h0000, 1'b1);
    for (int n = 0; n < 32767; n++) begin
      idle(1'b1);
      idle(1'b0);
    end
    step(1'b0, 1'b0, 1'b1, BASE + 16'd6, 16'h0000, 1'b1);
    #2 check("frame_max", {64'b0, bus_if.rdata}, {64'b0, 16'hFFFE});
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, BASE + 16'd6, 16'h0000, 1'b1);
    #2 check("frame_wrap", {64'b0, bus_if.rdata}, {64'b0, 16'h0000});

    idle(1'b1);
    idle(1'b1);
    check("drain", {48'b0, 32'(exp_q.size())}, 80'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
